// File: rtl/ins_exec_ld_ctrl_pkg.sv
// rtl/ins_exec_ld_ctrl_pkg.sv - shared constants, state type and helpers for the load controller
package ins_exec_ld_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD = 7'b0000011;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   localparam logic [1:0] CAUSE_NONE     = 2'd0;
   localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_REQ   = 2'd1,
      LD_WB    = 2'd2,
      LD_FAULT = 2'd3
   } ld_state_e;

   // Only the five RV32I load widths are legal
   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   // Halfwords need an even address, words a 4-byte aligned one
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] ea_lo);
      logic mis;
      mis = 1'b0;
      if ((f3 == F3_LH) || (f3 == F3_LHU)) mis = ea_lo[0];
      else if (f3 == F3_LW)                mis = (ea_lo != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/ins_exec_ld_ctrl_if.sv
// rtl/ins_exec_ld_ctrl_if.sv - data-memory read port and register write port bundle
interface ins_exec_ld_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              mem_r_req;
   logic [ADDR_W-1:0] mem_r_addr;
   logic              mem_r_ack;
   logic [31:0]       mem_val;
   logic              reg_w_op;
   logic [4:0]        reg_w_reg_idx;
   logic [31:0]       reg_w_reg_val;

   modport master (
      output mem_r_req, mem_r_addr, reg_w_op, reg_w_reg_idx, reg_w_reg_val,
      input  mem_r_ack, mem_val
   );

   modport slave (
      input  mem_r_req, mem_r_addr, reg_w_op, reg_w_reg_idx, reg_w_reg_val,
      output mem_r_ack, mem_val
   );
endinterface

// File: rtl/ins_exec_ld_ctrl_ld_lane_extract.sv
// rtl/ins_exec_ld_ctrl_ld_lane_extract.sv - selects the byte/half/word lane and sign/zero-extends it
module ins_exec_ld_ctrl_ld_lane_extract
   import ins_exec_ld_ctrl_pkg::*;
(
   input  logic [31:0] mem_val,
   input  logic [1:0]  ea_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane select by low address bits, then extend according to the load width
   always_comb begin
      byte_v = mem_val[7:0];
      case (ea_lo)
         2'd1:    byte_v = mem_val[15:8];
         2'd2:    byte_v = mem_val[23:16];
         2'd3:    byte_v = mem_val[31:24];
         default: byte_v = mem_val[7:0];
      endcase
      half_v = ea_lo[1] ? mem_val[31:16] : mem_val[15:0];

      result = '0;
      case (funct3)
         F3_LB:   result = {{24{byte_v[7]}}, byte_v};
         F3_LH:   result = {{16{half_v[15]}}, half_v};
         F3_LW:   result = mem_val;
         F3_LBU:  result = {24'd0, byte_v};
         F3_LHU:  result = {16'd0, half_v};
         default: result = '0;
      endcase
   end
endmodule

// File: rtl/ins_exec_ld_ctrl.sv
// rtl/ins_exec_ld_ctrl.sv - RV32I load sequencer (issue -> mem read -> writeback); optional LD_TIMEOUT_EN
module ins_exec_ld_ctrl
   import ins_exec_ld_ctrl_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  op,
   input  logic [6:0]            ins_dec_op,
   input  logic [2:0]            ins_dec_funct3,
   input  logic [31:0]           reg_rs1_val,
   input  logic [31:0]           ins_dec_imm,
   input  logic [4:0]            reg_rd,
   output logic                  busy,
   output logic                  ld_done,
   output logic                  ld_fault,
   output logic [1:0]            ld_fault_cause,
   ins_exec_ld_ctrl_if.master    bus
);
   ld_state_e         state_q, state_d;
   logic [ADDR_W-1:0] ea_q, ea_d;
   logic [2:0]        f3_q, f3_d;
   logic [4:0]        rd_q, rd_d;
   logic [31:0]       val_q, val_d;
   logic [1:0]        cause_q, cause_d;
   logic [31:0]       ea_sum;
   logic [31:0]       lane_val;

`ifdef LD_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_q, cnt_d;
`endif

   assign ea_sum = reg_rs1_val + ins_dec_imm;

   ins_exec_ld_ctrl_ld_lane_extract u_ld_lane_extract (
      .mem_val (bus.mem_val),
      .ea_lo   (ea_q[1:0]),
      .funct3  (f3_q),
      .result  (lane_val)
   );

   // Next-state and latched-operand logic
   always_comb begin
      state_d = state_q;
      ea_d    = ea_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      val_d   = val_q;
      cause_d = cause_q;
`ifdef LD_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         LD_IDLE: begin
            if (op && (ins_dec_op == OPC_LOAD)) begin
               ea_d = ea_sum[ADDR_W-1:0];
               f3_d = ins_dec_funct3;
               rd_d = reg_rd;
               if (!f3_legal(ins_dec_funct3)) begin
                  cause_d = CAUSE_ILLEGAL;
                  state_d = LD_FAULT;
               end else if (f3_misaligned(ins_dec_funct3, ea_sum[1:0])) begin
                  cause_d = CAUSE_MISALIGN;
                  state_d = LD_FAULT;
               end else begin
                  cause_d = CAUSE_NONE;
                  state_d = LD_REQ;
`ifdef LD_TIMEOUT_EN
                  cnt_d   = 8'd0;
`endif
               end
            end
         end
         LD_REQ: begin
            // An ack in the expiry cycle still wins over the timeout
            if (bus.mem_r_ack) begin
               val_d   = lane_val;
               state_d = LD_WB;
            end
`ifdef LD_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               cause_d = CAUSE_TIMEOUT;
               state_d = LD_FAULT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         LD_WB:    state_d = LD_IDLE;
         LD_FAULT: state_d = LD_IDLE;
         default:  state_d = LD_IDLE;
      endcase
   end

   // State and operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LD_IDLE;
         ea_q    <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         val_q   <= '0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         ea_q    <= ea_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         val_q   <= val_d;
         cause_q <= cause_d;
      end
   end

`ifdef LD_TIMEOUT_EN
   // Ack-wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`endif

   // Outputs decode straight from state so an async reset clears them at once
   assign busy               = (state_q != LD_IDLE);
   assign bus.mem_r_req      = (state_q == LD_REQ);
   assign bus.mem_r_addr     = (state_q == LD_REQ) ? {ea_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus.reg_w_op       = (state_q == LD_WB);
   assign bus.reg_w_reg_idx  = (state_q == LD_WB) ? rd_q : '0;
   assign bus.reg_w_reg_val  = (state_q == LD_WB) ? val_q : '0;
   assign ld_done            = (state_q == LD_WB) || (state_q == LD_FAULT);
   assign ld_fault           = (state_q == LD_FAULT);
   assign ld_fault_cause     = (state_q == LD_FAULT) ? cause_q : CAUSE_NONE;

endmodule

// File: tb/tb_ins_exec_ld_ctrl.sv
// tb/tb_ins_exec_ld_ctrl.sv - scoreboard bench for the load sequencer
module tb_ins_exec_ld_ctrl;
   import ins_exec_ld_ctrl_pkg::*;

   localparam int TO_CYC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op = 1'b0;
   logic [6:0]  ins_dec_op = '0;
   logic [2:0]  ins_dec_funct3 = '0;
   logic [31:0] reg_rs1_val = '0;
   logic [31:0] ins_dec_imm = '0;
   logic [4:0]  reg_rd = '0;
   logic        busy, ld_done, ld_fault;
   logic [1:0]  ld_fault_cause;

   ins_exec_ld_ctrl_if #(.ADDR_W(32)) bus ();

   ins_exec_ld_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .op             (op),
      .ins_dec_op     (ins_dec_op),
      .ins_dec_funct3 (ins_dec_funct3),
      .reg_rs1_val    (reg_rs1_val),
      .ins_dec_imm    (ins_dec_imm),
      .reg_rd         (reg_rd),
      .busy           (busy),
      .ld_done        (ld_done),
      .ld_fault       (ld_fault),
      .ld_fault_cause (ld_fault_cause),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fault;
      logic [1:0]  cause;
      logic [4:0]  idx;
      logic [31:0] val;
      logic [31:0] addr;
      int          lat;
      int          reqs;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          req_cnt = 0;
   bit          prev_w = 0;
   logic [31:0] mem_word = '0;
   int          ack_delay = 0;
   bit          ack_en = 1;
   int          wait_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      bus.mem_r_ack = 1'b0;
      bus.mem_val   = '0;
   end

   // Memory responder: acks after ack_delay REQ cycles, data valid only with ack
   always @(negedge clk) begin
      if (rst_n && bus.mem_r_req && ack_en) begin
         if (wait_cnt == ack_delay) begin
            bus.mem_r_ack = 1'b1;
            bus.mem_val   = mem_word;
            wait_cnt      = 0;
         end else begin
            bus.mem_r_ack = 1'b0;
            bus.mem_val   = ~mem_word;
            wait_cnt++;
         end
      end else begin
         bus.mem_r_ack = 1'b0;
         bus.mem_val   = ~mem_word;
         wait_cnt      = 0;
      end
   end

   // Monitor: checks request address, writeback idle values and completions
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_w = 0;
      end else begin
         if (bus.mem_r_req) begin
            req_cnt++;
            if (sb.size() == 0) check("req_unexpected", 1, 0);
            else                check("mem_r_addr", bus.mem_r_addr, sb[0].addr);
         end
         if (!bus.reg_w_op)
            check("wb_idle_zero", {27'd0, bus.reg_w_reg_idx} | bus.reg_w_reg_val, 0);
         if (bus.reg_w_op && prev_w) check("reg_w_op_pulse", 1, 0);
         prev_w = bus.reg_w_op;
         if (ld_fault && !ld_done) check("fault_without_done", 1, 0);
         if (ld_done) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               check("ld_fault", ld_fault, e.fault);
               check("ld_fault_cause", ld_fault_cause, e.cause);
               check("reg_w_op", bus.reg_w_op, !e.fault);
               if (!e.fault) begin
                  check("reg_w_reg_idx", bus.reg_w_reg_idx, e.idx);
                  check("reg_w_reg_val", bus.reg_w_reg_val, e.val);
               end
               check("latency", cyc - e.acc + 1, e.lat);
               check("req_cycles", req_cnt, e.reqs);
            end
            req_cnt = 0;
         end
      end
   end

   task automatic wait_not_busy();
      int n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) check("issue_wait_timeout", 1, 0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", sb.size(), 0);
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [31:0] word, input int dly,
                          input bit fault, input logic [1:0] cause, input logic [31:0] val,
                          input int lat, input int reqs, input bit do_drain);
      exp_t e;
      wait_not_busy();
      mem_word  = word;
      ack_delay = dly;
      e.fault = fault; e.cause = cause; e.idx = rd; e.val = val;
      e.addr  = (rs1 + imm) & 32'hFFFF_FFFC;
      e.lat   = lat; e.reqs = reqs; e.acc = 0;
      sb.push_back(e);
      op = 1'b1; ins_dec_op = OPC_LOAD; ins_dec_funct3 = f3;
      reg_rs1_val = rs1; ins_dec_imm = imm; reg_rd = rd;
      @(posedge clk); #1;
      sb[sb.size()-1].acc = cyc;
      op = 1'b0;
      if (do_drain) drain();
   endtask

   task automatic ok_load(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [31:0] word, input int dly,
                          input logic [31:0] val);
      do_load(f3, rs1, imm, rd, word, dly, 1'b0, CAUSE_NONE, val, 2 + dly, 1 + dly, 1'b1);
   endtask

   task automatic bad_load(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                           input logic [1:0] cause);
      do_load(f3, rs1, imm, 5'd1, 32'h0, 0, 1'b1, cause, 32'h0, 1, 0, 1'b1);
   endtask

   initial begin
      #12;
      check("rst_busy", busy, 0);
      check("rst_mem_r_req", bus.mem_r_req, 0);
      check("rst_mem_r_addr", bus.mem_r_addr, 0);
      check("rst_reg_w_op", bus.reg_w_op, 0);
      check("rst_ld_done", ld_done, 0);
      check("rst_ld_fault", {ld_fault, ld_fault_cause}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      ok_load(F3_LB,  32'h1000, 32'd3, 5'd5, 32'h80FF_1234, 2, 32'hFFFF_FF80);
      ok_load(F3_LHU, 32'h2000, 32'd2, 5'd6, 32'hBEEF_0000, 0, 32'h0000_BEEF);
      ok_load(F3_LB,  32'h0100, 32'd1, 5'd7, 32'h80FF_1234, 1, 32'h0000_0012);
      ok_load(F3_LBU, 32'h0100, 32'd3, 5'd8, 32'h80FF_1234, 0, 32'h0000_0080);
      ok_load(F3_LH,  32'h0200, 32'd2, 5'd9, 32'h80FF_1234, 0, 32'hFFFF_80FF);
      ok_load(F3_LHU, 32'h0300, 32'd0, 5'd10, 32'h1234_ABCD, 0, 32'h0000_ABCD);
      ok_load(F3_LBU, 32'h0300, 32'd0, 5'd11, 32'h1234_ABCD, 3, 32'h0000_00CD);
      ok_load(F3_LW,  32'h5000, 32'hFFFF_FFFC, 5'd0, 32'h1234_5678, 1, 32'h1234_5678);

      bad_load(F3_LW, 32'h3000, 32'd1, CAUSE_MISALIGN);
      bad_load(F3_LH, 32'h3000, 32'd3, CAUSE_MISALIGN);
      bad_load(3'd3,  32'h3000, 32'd0, CAUSE_ILLEGAL);
      bad_load(3'd7,  32'h3000, 32'd1, CAUSE_ILLEGAL);

      // op during the FAULT cycle must be ignored
      do_load(3'd3, 32'h3000, 32'd0, 5'd1, 32'h0, 0, 1'b1, CAUSE_ILLEGAL, 32'h0, 1, 0, 1'b0);
      op = 1'b1; ins_dec_op = OPC_LOAD; ins_dec_funct3 = F3_LW;
      reg_rs1_val = 32'h40; ins_dec_imm = 32'h0; reg_rd = 5'd12;
      @(posedge clk); #1;
      op = 1'b0;
      @(negedge clk);
      check("busy_after_fault", busy, 0);
      ok_load(F3_LW, 32'h5000, 32'hFFFF_FFFC, 5'd13, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);

      // op during REQ must be ignored
      do_load(F3_LB, 32'h1000, 32'd3, 5'd14, 32'h7F00_0000, 2, 1'b0, CAUSE_NONE,
              32'h0000_007F, 4, 3, 1'b0);
      op = 1'b1;
      @(posedge clk); #1;
      op = 1'b0;
      drain();

      // Non-load opcode is ignored
      op = 1'b1; ins_dec_op = 7'b0010011;
      @(posedge clk); #1;
      op = 1'b0;
      @(negedge clk);
      check("non_load_busy", busy, 0);
      check("non_load_req", bus.mem_r_req, 0);

      // Reset while waiting in REQ
      ack_en = 0;
      do_load(F3_LW, 32'h4000, 32'd0, 5'd15, 32'h0, 0, 1'b0, CAUSE_NONE, 32'h0, 0, 0, 1'b0);
      @(negedge clk);
      check("req_before_reset", bus.mem_r_req, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_req_drop", bus.mem_r_req, 0);
      check("rst_async_busy", busy, 0);
      check("rst_async_reg_w_op", bus.reg_w_op, 0);
      sb.delete();
      req_cnt = 0;
      ack_en = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ok_load(F3_LH, 32'h0008, 32'd8, 5'd16, 32'h0000_8001, 0, 32'hFFFF_8001);

`ifdef LD_TIMEOUT_EN
      ack_en = 0;
      do_load(F3_LW, 32'h6000, 32'd0, 5'd17, 32'h0, 0, 1'b1, CAUSE_TIMEOUT, 32'h0,
              1 + TO_CYC, TO_CYC, 1'b1);
      ack_en = 1;
      ok_load(F3_LW, 32'h6000, 32'd0, 5'd18, 32'h0BAD_BEEF, TO_CYC - 1, 32'h0BAD_BEEF);
`endif

      drain();
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ins_exec_ld_ctrl.md
Name: ins_exec_ld_ctrl

Overview:
- Sequences RV32I loads (opcode 7'b0000011) from issue to register writeback.
- Takes a decoded load (base, imm, funct3, rd) and computes the effective address.
- Runs a req/ack read handshake with the data-memory port, extracts and extends the byte, half or word lane, and issues a one-cycle register write.
- Sits between the decoder/issue stage and the data-memory port; stalls issue via busy.

Parameters:
- ADDR_W, 32, effective/memory address width.
- TIMEOUT_CYCLES, 16, max cycles waiting for mem_r_ack (only with LD_TIMEOUT_EN).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op  in  1  issue strobe; accepted only in IDLE
- ins_dec_op  in  7  decoded opcode
- ins_dec_funct3  in  3  load width/sign select
- reg_rs1_val  in  32  base register value
- ins_dec_imm  in  32  sign-extended I-immediate
- reg_rd  in  5  destination register index
- busy  out  1  high whenever state != IDLE
- mem_r_req  out  1  read request, held until ack
- mem_r_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
- mem_r_ack  in  1  read data valid this cycle
- mem_val  in  32  read word; sampled only when mem_r_ack
- reg_w_op  out  1  register write strobe, one cycle
- reg_w_reg_idx  out  5  write index
- reg_w_reg_val  out  32  write value
- ld_done  out  1  one-cycle completion pulse (normal or fault)
- ld_fault  out  1  one-cycle pulse with ld_done when the load faulted
- ld_fault_cause  out  2  0=none, 1=misaligned, 2=illegal funct3, 3=timeout

Behaviour:
- Reset: the clock is clk; reset rst_n is asynchronous and active-low. All outputs go to 0 and state to IDLE. Reset mid-transaction drops mem_r_req immediately; no writeback occurs.
- States: IDLE, REQ, WB, FAULT.
- IDLE:
  - Accept when op && ins_dec_op==7'b0000011.
  - Latch ea = reg_rs1_val + ins_dec_imm (mod 2^32), funct3 and rd.
  - funct3 not in {0,1,2,4,5} -> FAULT, cause 2.
  - Misaligned -> FAULT, cause 1: half with ea[0]=1, or word with ea[1:0]!=0.
  - Otherwise -> REQ.
  - op with any other opcode is ignored.
- REQ:
  - mem_r_req=1, mem_r_addr={ea[ADDR_W-1:2],2'b00}; both held stable until mem_r_ack.
  - On ack, latch the extracted value and go to WB.
  - Ack in the same cycle req first rises is legal, giving the minimum latency.
- Lane extraction (ea[1:0]):
  - Byte: mem_val[8*ea[1:0] +: 8].
  - Half: mem_val[16*ea[1] +: 16].
  - funct3 0 (LB) / 1 (LH): sign-extend by replicating bit 7 / bit 15.
  - funct3 4 (LBU) / 5 (LHU): zero-extend.
  - funct3 2 (LW): word unchanged.
- WB:
  - reg_w_op=1, reg_w_reg_idx=rd, reg_w_reg_val=value, ld_done=1 for one cycle, then IDLE.
  - rd==0 still issues the strobe; the register file discards it.
- FAULT: ld_done=1, ld_fault=1, ld_fault_cause set, reg_w_op=0, mem_r_req never asserted; one cycle, then IDLE.
- Latency:
  - Accept to writeback strobe = 2 + ack-wait cycles (ack on first REQ cycle -> reg_w_op in the cycle after).
  - Fault is reported 1 cycle after accept.
- Back-to-back: busy falls in the cycle after WB/FAULT. op while busy is ignored; issue must hold op.
- mem_r_ack outside REQ is ignored.
- reg_w_reg_idx and reg_w_reg_val are 0 whenever reg_w_op=0.

Optional Feature:
- Macro LD_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on REQ entry and increments each REQ cycle without ack.
  - Reaching TIMEOUT_CYCLES drops mem_r_req and goes to FAULT, cause 3.
  - Ack in the same cycle as expiry wins; writeback proceeds.
- Undefined: no counter; REQ waits indefinitely; cause 3 never produced.

Decomposition:
- Shared package: OPC_LOAD=7'b0000011; F3_LB/LH/LW/LBU/LHU; ld_state enum; fault-cause constants.
- Sub-module ld_lane_extract: combinational mem_val + ea[1:0] + funct3 -> 32-bit extended result, reusable by the later misaligned-access/store path.

Test Plan:
- LB, rs1=0x1000, imm=3, mem_val=0x80FF_1234, ack 2 cycles after req -> mem_r_addr=0x1000, reg_w_reg_val=0xFFFF_FF80, ld_done pulse.
- LHU, ea=0x2002, mem_val=0xBEEF_0000, immediate ack -> reg_w_reg_val=0x0000_BEEF, reg_w_op exactly one cycle, the cycle after REQ.
- LW, ea=0x3001 -> no mem_r_req; ld_fault=1, cause=1, reg_w_op=0, one cycle after accept.
- funct3=3 -> ld_fault, cause=2; op pulsed while busy is ignored and a second load issues after busy falls.
- rst_n low while in REQ -> mem_r_req drops asynchronously, no reg_w_op; after release a new LH at ea=0x10, mem_val=0x0000_8001 writes 0xFFFF_8001.
- LD_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_r_req high 4 cycles, then ld_fault cause=3; repeat with ack on the 4th cycle -> normal writeback.
